// File: rtl/instr_assembler.sv
// Instruction assembler: pulls two bytes (low byte first) from the RX FIFO,
// joins them into one 16-bit instruction word, decodes the control fields and
// presents the result to the control FSM. A low byte whose high byte does not
// arrive within TIMEOUT_CYCLES is dropped.
//
// Handshake: instr_valid rises with registered, decoded fields. The fields stay
// stable while instr_valid && !instr_ready. A transfer happens on any rising
// clk edge where instr_valid && instr_ready. instr_valid then drops on the
// following cycle, and the next fetch begins.
module instr_assembler #(
    parameter int DATA_WIDTH     = 8,
    parameter int INSTR_WIDTH    = 16,
    parameter int OPCODE_WIDTH   = 3,
    parameter int ADDRESS_SIZE   = 9,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int COUNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    rx_empty,
    output logic                    rx_re,
    input  logic [DATA_WIDTH-1:0]   rx_data,
    input  logic                    rx_valid,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic [OPCODE_WIDTH-1:0] opcode,
    output logic [ADDRESS_SIZE-1:0] address,
    output logic                    compute_en,
    output logic                    quant_en,
    output logic                    relu_en,
    output logic                    bot_mem,
    output logic                    load_en,
    output logic                    addr_indicator,
    output logic                    is_nop,
    output logic                    illegal,
    output logic                    instruction_half,
    output logic                    timeout_pulse,
    output logic [COUNT_W-1:0]      instr_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_LO = 3'd1,
        RD_LO   = 3'd2,
        WAIT_HI = 3'd3,
        RD_HI   = 3'd4,
        ISSUE   = 3'd5
    } state_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_FETCH = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_RUN   = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = OPCODE_WIDTH'(5);

    // Timeout counter wide enough to hold TIMEOUT_CYCLES; at least one bit.
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t                  state;
    logic [DATA_WIDTH-1:0]   lo_byte;
    logic [TW-1:0]           tcnt;
    logic [INSTR_WIDTH-1:0]  word;
    logic                    tmo_hit;

    logic [OPCODE_WIDTH-1:0] d_opcode;
    logic [ADDRESS_SIZE-1:0] d_address;
    logic                    d_compute_en;
    logic                    d_quant_en;
    logic                    d_relu_en;
    logic                    d_bot_mem;
    logic                    d_load_en;
    logic                    d_addr_indicator;
    logic                    d_is_nop;
    logic                    d_illegal;

    // The high byte arrives on rx_data while the low byte sits in lo_byte.
    assign word = {rx_data, lo_byte};

    // Pop only while waiting for a byte and only when the FIFO has one.
    assign rx_re = ((state == WAIT_LO) || (state == WAIT_HI)) && !rx_empty;

    // The timeout window ends on the TIMEOUT_CYCLES-th cycle spent waiting for the high byte.
    always_comb begin
        tmo_hit = 1'b0;
        if ((TIMEOUT_CYCLES != 0) && ((state == WAIT_HI) || (state == RD_HI)) && (tcnt == TO_LAST))
            tmo_hit = 1'b1;
    end

    // Decode the candidate word; per-opcode enables are gated to their own opcode.
    always_comb begin
        d_opcode         = word[OPCODE_WIDTH-1:0];
        d_address        = word[INSTR_WIDTH-1 -: ADDRESS_SIZE];
        d_compute_en     = (d_opcode == OP_RUN)   && word[3];
        d_quant_en       = (d_opcode == OP_RUN)   && word[4];
        d_relu_en        = (d_opcode == OP_RUN)   && word[5];
        d_bot_mem        = (d_opcode == OP_FETCH) && word[3];
        d_load_en        = (d_opcode == OP_LOAD)  && word[3];
        d_addr_indicator = (d_opcode == OP_STORE) && word[4];
        d_is_nop         = (d_opcode == OP_NOP);
        d_illegal        = !((d_opcode == OP_STORE) || (d_opcode == OP_FETCH) ||
                             (d_opcode == OP_RUN)   || (d_opcode == OP_LOAD)  ||
                             (d_opcode == OP_NOP));
    end

    // Fetch/assemble/issue FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            lo_byte          <= '0;
            tcnt             <= '0;
            instr_valid      <= 1'b0;
            opcode           <= '0;
            address          <= '0;
            compute_en       <= 1'b0;
            quant_en         <= 1'b0;
            relu_en          <= 1'b0;
            bot_mem          <= 1'b0;
            load_en          <= 1'b0;
            addr_indicator   <= 1'b0;
            is_nop           <= 1'b0;
            illegal          <= 1'b0;
            instruction_half <= 1'b0;
            timeout_pulse    <= 1'b0;
            instr_count      <= '0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (start)
                        state <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (rx_re)
                        state <= RD_LO;
                end
                RD_LO: begin
                    if (rx_valid) begin
                        lo_byte          <= rx_data;
                        instruction_half <= 1'b1;
                        tcnt             <= '0;
                        state            <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    tcnt <= tcnt + TW'(1);
                    // A pop already under way wins over the timeout so no FIFO byte is lost.
                    if (rx_re) begin
                        state <= RD_HI;
                    end else if (tmo_hit) begin
                        lo_byte          <= '0;
                        instruction_half <= 1'b0;
                        timeout_pulse    <= 1'b1;
                        state            <= WAIT_LO;
                    end
                end
                RD_HI: begin
                    if (rx_valid) begin
                        opcode           <= d_opcode;
                        address          <= d_address;
                        compute_en       <= d_compute_en;
                        quant_en         <= d_quant_en;
                        relu_en          <= d_relu_en;
                        bot_mem          <= d_bot_mem;
                        load_en          <= d_load_en;
                        addr_indicator   <= d_addr_indicator;
                        is_nop           <= d_is_nop;
                        illegal          <= d_illegal;
                        instr_valid      <= 1'b1;
                        instruction_half <= 1'b0;
                        state            <= ISSUE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                        if (tmo_hit) begin
                            lo_byte          <= '0;
                            instruction_half <= 1'b0;
                            timeout_pulse    <= 1'b1;
                            state            <= WAIT_LO;
                        end
                    end
                end
                ISSUE: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        instr_count <= instr_count + COUNT_W'(1);
                        state       <= WAIT_LO;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_assembler.sv
// Directed bench for instr_assembler: a byte-FIFO model feeds the DUT, expected
// decoded fields are queued when bytes are pushed and compared at issue time.
module tb_instr_assembler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        rx_empty;
    logic        rx_re;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [2:0]  opcode;
    logic [8:0]  address;
    logic        compute_en;
    logic        quant_en;
    logic        relu_en;
    logic        bot_mem;
    logic        load_en;
    logic        addr_indicator;
    logic        is_nop;
    logic        illegal;
    logic        instruction_half;
    logic        timeout_pulse;
    logic [15:0] instr_count;

    int          errors = 0;
    int          checks = 0;
    logic [19:0] exp_q[$];
    logic [15:0] exp_count = 16'd0;

    // FIFO model: written by the stimulus, read by the pop process.
    logic [7:0]  fifo_mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        re_while_empty = 1'b0;

    logic [19:0] dec_vec;
    logic [41:0] all_out;

    assign rx_empty = (wr_ptr == rd_ptr);
    assign dec_vec  = {opcode, address, compute_en, quant_en, relu_en, bot_mem,
                       load_en, addr_indicator, is_nop, illegal};
    assign all_out  = {dec_vec, instr_valid, rx_re, instruction_half, timeout_pulse, instr_count};

    instr_assembler #(
        .DATA_WIDTH(8), .INSTR_WIDTH(16), .OPCODE_WIDTH(3), .ADDRESS_SIZE(9),
        .TIMEOUT_CYCLES(64), .COUNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .rx_empty(rx_empty), .rx_re(rx_re),
        .rx_data(rx_data), .rx_valid(rx_valid), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .opcode(opcode), .address(address),
        .compute_en(compute_en), .quant_en(quant_en), .relu_en(relu_en),
        .bot_mem(bot_mem), .load_en(load_en), .addr_indicator(addr_indicator),
        .is_nop(is_nop), .illegal(illegal), .instruction_half(instruction_half),
        .timeout_pulse(timeout_pulse), .instr_count(instr_count)
    );

    // Clock
    always #5 clk = ~clk;

    // FIFO read side: data and valid return the cycle after a pop.
    always @(posedge clk) begin
        rx_valid <= rx_re;
        if (rx_re) begin
            rx_data <= fifo_mem[rd_ptr[7:0]];
            rd_ptr  <= rd_ptr + 1;
        end
        if (rx_re && rx_empty)
            re_while_empty <= 1'b1;
    end

    // Reference decode written from the opcode table.
    function automatic logic [19:0] model(input logic [15:0] w);
        logic [2:0] op;
        op = w[2:0];
        model = {op, w[15:7],
                 (op == 3'd2) & w[3], (op == 3'd2) & w[4], (op == 3'd2) & w[5],
                 (op == 3'd1) & w[3], (op == 3'd3) & w[3], (op == 3'd0) & w[4],
                 (op == 3'd5), (op == 3'd4) | (op == 3'd6) | (op == 3'd7)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_mem[wr_ptr[7:0]] = b;
        wr_ptr++;
    endtask

    task automatic push_instr(input logic [7:0] lo, input logic [7:0] hi);
        push_byte(lo);
        push_byte(hi);
        exp_q.push_back(model({hi, lo}));
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_half();
        int n;
        n = 0;
        while (instruction_half !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("half_seen", 64'(instruction_half), 64'd1);
    endtask

    // Wait for an issued instruction, compare it, and follow the handshake if ready is high.
    task automatic wait_issue(input string tag);
        int n;
        logic [19:0] exp;
        n = 0;
        while (instr_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 64'(instr_valid), 64'd1);
        if (instr_valid === 1'b1) begin
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 20'h0;
            check({tag, "_fields"}, 64'(dec_vec), 64'(exp));
            if (instr_ready === 1'b1) begin
                @(negedge clk);
                exp_count++;
                check({tag, "_count"}, 64'(instr_count), 64'(exp_count));
                check({tag, "_vdrop"}, 64'(instr_valid), 64'd0);
            end
        end
    endtask

    initial begin
        logic [19:0] held;
        logic        early;
        logic        bad;

        // Reset
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'(all_out), 64'd0);
        rst = 1'b0;

        // 1: RUN word 0x091A
        push_instr(8'h1A, 8'h09);
        pulse_start();
        wait_issue("run");

        // 2: FETCH word 0x1A09
        push_instr(8'h09, 8'h1A);
        wait_issue("fetch");

        // 3: LOAD word 0x2A0B held by backpressure with a STORE word queued behind
        instr_ready = 1'b0;
        push_instr(8'h0B, 8'h2A);
        push_instr(8'h10, 8'h80);
        wait_issue("load");
        held = model(16'h2A0B);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_fields", 64'(dec_vec), 64'(held));
            check("hold_no_pop", 64'(rx_re), 64'd0);
            check("hold_valid", 64'(instr_valid), 64'd1);
        end
        check("hold_count", 64'(instr_count), 64'(exp_count));
        instr_ready = 1'b1;
        @(negedge clk);
        exp_count++;
        check("load_count", 64'(instr_count), 64'(exp_count));
        check("load_vdrop", 64'(instr_valid), 64'd0);
        check("next_pop", 64'(rx_re), 64'd1);
        wait_issue("store");

        // 4: lone low byte times out after 64 cycles, then a NOP assembles normally
        push_byte(8'h05);
        wait_half();
        early = 1'b0;
        for (int k = 1; k < 64; k++) begin
            @(negedge clk);
            if (timeout_pulse !== 1'b0 || instruction_half !== 1'b1)
                early = 1'b1;
        end
        check("tmo_early", 64'(early), 64'd0);
        @(negedge clk);
        check("tmo_pulse", 64'(timeout_pulse), 64'd1);
        check("tmo_half", 64'(instruction_half), 64'd0);
        @(negedge clk);
        check("tmo_one_cycle", 64'(timeout_pulse), 64'd0);
        push_instr(8'h05, 8'h00);
        wait_issue("nop");

        // 5: illegal opcode still handshaked
        push_instr(8'h07, 8'h00);
        wait_issue("illegal");

        // 6: reset while waiting for the high byte
        push_byte(8'h21);
        wait_half();
        rst = 1'b1;
        #1;
        check("rst_mid_word", 64'(all_out), 64'd0);
        @(negedge clk);
        push_instr(8'h03, 8'h00);
        rst = 1'b0;
        exp_count = 16'd0;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rx_re !== 1'b0 || instr_valid !== 1'b0)
                bad = 1'b1;
        end
        check("idle_after_rst", 64'(bad), 64'd0);
        pulse_start();
        wait_issue("after_rst");

        check("re_while_empty", 64'(re_while_empty), 64'd0);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
